// File: rtl/xc_rf_wb_seq_pkg.sv
// Shared types and widths for the register-file write-back sequencer.
// A queue entry packs {wide, rd[4:0], data[63:0]} into 70 bits.
package xc_rf_wb_seq_pkg;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int ENT_W = 1 + AW + 2 * DW;
  localparam int TAG_W = 1 + AW;

  typedef struct packed {
    logic          wide;
    logic [AW-1:0] rd;
    logic [63:0]   data;
  } wb_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HI   = 1'b1
  } wb_state_e;

  // A wide entry owns the whole even/odd pair; x0 is never a hazard.
  function automatic logic tag_hits(input logic [TAG_W-1:0] tag, input logic [AW-1:0] addr);
    logic          wide;
    logic [AW-1:0] rd;
    wide = tag[TAG_W-1];
    rd   = tag[AW-1:0];
    if (addr == '0)
      return 1'b0;
    return wide ? (rd[AW-1:1] == addr[AW-1:1]) : (rd == addr);
  endfunction

endpackage

// File: rtl/xc_wb_fifo.sv
// DEPTH-entry synchronous request FIFO; exposes per-slot tags and valid bits
// so the top level can run hazard compares against every queued entry.
module xc_wb_fifo
  import xc_rf_wb_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ENT_W-1:0]         din_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [ENT_W-1:0]         head_o,
  output logic [DEPTH*TAG_W-1:0]   tags_o,
  output logic [DEPTH-1:0]         valid_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; valid_o masks stale slots, and
  // leaving the array out of reset lets it map onto plain RAM/flops.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    tags_o  = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tags_o[i*TAG_W +: TAG_W] = mem_q[i][ENT_W-1 -: TAG_W];
      valid_o[i]               = ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q);
    end
  end

endmodule

// File: rtl/xc_rf_wb_seq.sv
// Write-back sequencer: sole driver of the register-file write port, issuing
// queued narrow/wide results one register per cycle and flagging hazards.
module xc_rf_wb_seq
  import xc_rf_wb_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wide,
  input  logic [AW-1:0] req_rd,
  input  logic [63:0]   req_wdata,
  output logic          rd_wen,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_wdata,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rs3_addr,
  output logic          rs1_hz,
  output logic          rs2_hz,
  output logic          rs3_hz,
  output logic          busy
);

  wb_state_e              state_q, state_d;
  logic                   push, pop, full, empty, wr_en;
  logic [ENT_W-1:0]       head_raw;
  wb_entry_t              head;
  logic [DEPTH*TAG_W-1:0] tags;
  logic [DEPTH-1:0]       valid;

  assign req_ready = !full && !reset;
  assign push      = req_valid && req_ready;
  assign busy      = !empty && !reset;
  assign head      = wb_entry_t'(head_raw);

  xc_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({req_wide, req_rd, req_wdata}),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head_raw),
    .tags_o  (tags),
    .valid_o (valid)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    wr_en    = 1'b0;
    rd_addr  = '0;
    rd_wdata = '0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            wr_en    = 1'b1;
            rd_wdata = head.data[DW-1:0];
            if (head.wide) begin
              rd_addr = {head.rd[AW-1:1], 1'b0};
              state_d = ST_HI;
            end else begin
              rd_addr = head.rd;
              pop     = 1'b1;
            end
          end
        end
        ST_HI: begin
          wr_en    = 1'b1;
          rd_addr  = {head.rd[AW-1:1], 1'b1};
          rd_wdata = head.data[2*DW-1:DW];
          pop      = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // x0 writes still consume their slot but never reach the register file.
  assign rd_wen = wr_en && (rd_addr != '0);

  always_comb begin
    rs1_hz = 1'b0;
    rs2_hz = 1'b0;
    rs3_hz = 1'b0;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          rs1_hz = rs1_hz | tag_hits(tags[i*TAG_W +: TAG_W], rs1_addr);
          rs2_hz = rs2_hz | tag_hits(tags[i*TAG_W +: TAG_W], rs2_addr);
          rs3_hz = rs3_hz | tag_hits(tags[i*TAG_W +: TAG_W], rs3_addr);
        end
      end
    end
  end

endmodule

// File: tb/tb_xc_rf_wb_seq.sv
// Directed bench for xc_rf_wb_seq: inputs driven at negedge, outputs sampled
// 1 time unit later, expected values hand-computed per scenario.
module tb_xc_rf_wb_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wide;
  logic [4:0]  req_rd;
  logic [63:0] req_wdata;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
  logic        rs1_hz, rs2_hz, rs3_hz, busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  xc_rf_wb_seq #(.DEPTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wide  (req_wide),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .rd_wen    (rd_wen),
    .rd_addr   (rd_addr),
    .rd_wdata  (rd_wdata),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs3_addr  (rs3_addr),
    .rs1_hz    (rs1_hz),
    .rs2_hz    (rs2_hz),
    .rs3_hz    (rs3_hz),
    .busy      (busy)
  );

  task automatic offer(input logic v, input logic w, input logic [4:0] rd, input logic [63:0] d);
    req_valid = v;
    req_wide  = w;
    req_rd    = rd;
    req_wdata = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rs1_addr = 5'd3; rs2_addr = 5'd4; rs3_addr = 5'd5;
    offer(1'b1, 1'b0, 5'd3, 64'h1);
    repeat (2) @(negedge clock);
    #1;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %0b exp 0", req_ready); else n_pass++;
    n_chk++; if (rd_wen !== 1'b0) $display("FAIL rst_wen got %0b exp 0", rd_wen); else n_pass++;
    n_chk++; if (rd_addr !== 5'd0) $display("FAIL rst_addr got %0h exp 0", rd_addr); else n_pass++;
    n_chk++; if (rd_wdata !== 32'd0) $display("FAIL rst_wdata got %0h exp 0", rd_wdata); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
    n_chk++; if ({rs1_hz, rs2_hz, rs3_hz} !== 3'b000) $display("FAIL rst_hz got %0b exp 000", {rs1_hz, rs2_hz, rs3_hz}); else n_pass++;
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_rel_ready got %0b exp 1", req_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_rel_busy got %0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_narrow;
    @(negedge clock);
    offer(1'b1, 1'b0, 5'd5, 64'h0000_0000_DEAD_BEEF);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL nar_ready got %0b exp 1", req_ready); else n_pass++;
    n_chk++; if (rd_wen !== 1'b0) $display("FAIL nar_pre_wen got %0b exp 0", rd_wen); else n_pass++;
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if (rd_wen !== 1'b1) $display("FAIL nar_wen got %0b exp 1", rd_wen); else n_pass++;
    n_chk++; if (rd_addr !== 5'd5) $display("FAIL nar_addr got %0h exp 5", rd_addr); else n_pass++;
    n_chk++; if (rd_wdata !== 32'hDEAD_BEEF) $display("FAIL nar_data got %0h exp deadbeef", rd_wdata); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL nar_busy got %0b exp 1", busy); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL nar_busy_fall got %0b exp 0", busy); else n_pass++;
    n_chk++; if (rd_wen !== 1'b0) $display("FAIL nar_post_wen got %0b exp 0", rd_wen); else n_pass++;
  endtask

  task automatic test_wide;
    @(negedge clock);
    offer(1'b1, 1'b1, 5'd7, 64'h1111_2222_3333_4444);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL wide_ready got %0b exp 1", req_ready); else n_pass++;
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if (rd_wen !== 1'b1) $display("FAIL wide_lo_wen got %0b exp 1", rd_wen); else n_pass++;
    n_chk++; if (rd_addr !== 5'd6) $display("FAIL wide_lo_addr got %0h exp 6", rd_addr); else n_pass++;
    n_chk++; if (rd_wdata !== 32'h3333_4444) $display("FAIL wide_lo_data got %0h exp 33334444", rd_wdata); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (rd_wen !== 1'b1) $display("FAIL wide_hi_wen got %0b exp 1", rd_wen); else n_pass++;
    n_chk++; if (rd_addr !== 5'd7) $display("FAIL wide_hi_addr got %0h exp 7", rd_addr); else n_pass++;
    n_chk++; if (rd_wdata !== 32'h1111_2222) $display("FAIL wide_hi_data got %0h exp 11112222", rd_wdata); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL wide_hi_busy got %0b exp 1", busy); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (rd_wen !== 1'b0) $display("FAIL wide_done_wen got %0b exp 0", rd_wen); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL wide_done_busy got %0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_full;
    @(negedge clock);
    offer(1'b1, 1'b0, 5'd3, 64'h0000_0000_0000_0333);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL full_a_ready got %0b exp 1", req_ready); else n_pass++;
    @(negedge clock);
    offer(1'b1, 1'b1, 5'd8, 64'h0000_0999_0000_0888);
    #1;
    n_chk++; if (rd_addr !== 5'd3 || rd_wen !== 1'b1) $display("FAIL full_w3 got addr %0h wen %0b exp 3/1", rd_addr, rd_wen); else n_pass++;
    n_chk++; if (rd_wdata !== 32'h333) $display("FAIL full_w3_data got %0h exp 333", rd_wdata); else n_pass++;
    @(negedge clock);
    offer(1'b1, 1'b0, 5'd20, 64'h0000_0000_0000_0A20);
    #1;
    n_chk++; if (rd_addr !== 5'd8 || rd_wdata !== 32'h888) $display("FAIL full_w8 got %0h/%0h exp 8/888", rd_addr, rd_wdata); else n_pass++;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL full_c_ready got %0b exp 1", req_ready); else n_pass++;
    @(negedge clock);
    offer(1'b1, 1'b0, 5'd21, 64'h0000_0000_0000_0A21);
    #1;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL full_ready_low got %0b exp 0", req_ready); else n_pass++;
    n_chk++; if (rd_addr !== 5'd9 || rd_wdata !== 32'h999 || rd_wen !== 1'b1) $display("FAIL full_w9 got %0h/%0h exp 9/999", rd_addr, rd_wdata); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL full_ready_back got %0b exp 1", req_ready); else n_pass++;
    n_chk++; if (rd_addr !== 5'd20 || rd_wdata !== 32'hA20) $display("FAIL full_w20 got %0h/%0h exp 14/a20", rd_addr, rd_wdata); else n_pass++;
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if (rd_addr !== 5'd21 || rd_wdata !== 32'hA21) $display("FAIL full_w21 got %0h/%0h exp 15/a21", rd_addr, rd_wdata); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL full_drain_busy got %0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [4:0]  req_rds  [3];
    logic        req_wds  [3];
    logic [63:0] req_dat  [3];
    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];
    req_rds[0] = 5'd2;  req_wds[0] = 1'b0; req_dat[0] = 64'h2;
    req_rds[1] = 5'd4;  req_wds[1] = 1'b0; req_dat[1] = 64'h4;
    req_rds[2] = 5'd16; req_wds[2] = 1'b1; req_dat[2] = 64'h0000_0017_0000_0016;
    exp_addr[0] = 5'd2;  exp_data[0] = 32'h2;
    exp_addr[1] = 5'd4;  exp_data[1] = 32'h4;
    exp_addr[2] = 5'd16; exp_data[2] = 32'h16;
    exp_addr[3] = 5'd17; exp_data[3] = 32'h17;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k < 3) offer(1'b1, req_wds[k], req_rds[k], req_dat[k]);
      else       offer(1'b0, 1'b0, 5'd0, 64'h0);
      #1;
      if (k < 3) begin
        n_chk++; if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %0b exp 1", k, req_ready); else n_pass++;
      end
      if (k >= 1 && k <= 4) begin
        n_chk++;
        if (rd_wen !== 1'b1 || rd_addr !== exp_addr[k-1] || rd_wdata !== exp_data[k-1])
          $display("FAIL b2b_write[%0d] got wen %0b addr %0h data %0h exp 1/%0h/%0h",
                   k, rd_wen, rd_addr, rd_wdata, exp_addr[k-1], exp_data[k-1]);
        else n_pass++;
      end
      if (k == 5) begin
        n_chk++; if (busy !== 1'b0) $display("FAIL b2b_busy got %0b exp 0", busy); else n_pass++;
      end
    end
  endtask

  task automatic test_x0;
    @(negedge clock);
    rs1_addr = 5'd0; rs2_addr = 5'd1; rs3_addr = 5'd0;
    offer(1'b1, 1'b1, 5'd1, 64'hAAAA_0001_BBBB_0000);
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if (rd_wen !== 1'b0) $display("FAIL x0_lo_wen got %0b exp 0", rd_wen); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL x0_lo_busy got %0b exp 1", busy); else n_pass++;
    n_chk++; if (rs2_hz !== 1'b1 || rs1_hz !== 1'b0) $display("FAIL x0_hz got rs1 %0b rs2 %0b exp 0/1", rs1_hz, rs2_hz); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (rd_wen !== 1'b1 || rd_addr !== 5'd1) $display("FAIL x0_hi got wen %0b addr %0h exp 1/1", rd_wen, rd_addr); else n_pass++;
    n_chk++; if (rd_wdata !== 32'hAAAA_0001) $display("FAIL x0_hi_data got %0h exp aaaa0001", rd_wdata); else n_pass++;
    @(negedge clock);
    offer(1'b1, 1'b0, 5'd0, 64'h55);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL x0_pair_done got %0b exp 0", busy); else n_pass++;
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if (rd_wen !== 1'b0 || busy !== 1'b1) $display("FAIL x0_narrow got wen %0b busy %0b exp 0/1", rd_wen, busy); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL x0_narrow_consumed got %0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_hazard;
    @(negedge clock);
    rs1_addr = 5'd11; rs2_addr = 5'd10; rs3_addr = 5'd0;
    offer(1'b1, 1'b1, 5'd10, 64'h0000_00BB_0000_00AA);
    #1;
    n_chk++; if ({rs1_hz, rs2_hz, rs3_hz} !== 3'b000) $display("FAIL hz_same_cycle got %0b exp 000", {rs1_hz, rs2_hz, rs3_hz}); else n_pass++;
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if ({rs1_hz, rs2_hz, rs3_hz} !== 3'b110) $display("FAIL hz_lo got %0b exp 110", {rs1_hz, rs2_hz, rs3_hz}); else n_pass++;
    n_chk++; if (rd_addr !== 5'd10 || rd_wdata !== 32'hAA) $display("FAIL hz_lo_write got %0h/%0h exp a/aa", rd_addr, rd_wdata); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if ({rs1_hz, rs2_hz, rs3_hz} !== 3'b110) $display("FAIL hz_hi got %0b exp 110", {rs1_hz, rs2_hz, rs3_hz}); else n_pass++;
    n_chk++; if (rd_addr !== 5'd11 || rd_wdata !== 32'hBB) $display("FAIL hz_hi_write got %0h/%0h exp b/bb", rd_addr, rd_wdata); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if ({rs1_hz, rs2_hz, rs3_hz} !== 3'b000) $display("FAIL hz_clear got %0b exp 000", {rs1_hz, rs2_hz, rs3_hz}); else n_pass++;
    @(negedge clock);
    rs3_addr = 5'd10;
    offer(1'b1, 1'b0, 5'd10, 64'hCC);
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if ({rs1_hz, rs2_hz, rs3_hz} !== 3'b011) $display("FAIL hz_narrow got %0b exp 011", {rs1_hz, rs2_hz, rs3_hz}); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if ({rs1_hz, rs2_hz, rs3_hz} !== 3'b000) $display("FAIL hz_narrow_clear got %0b exp 000", {rs1_hz, rs2_hz, rs3_hz}); else n_pass++;
  endtask

  task automatic test_reset_mid_wide;
    @(negedge clock);
    offer(1'b1, 1'b1, 5'd12, 64'h0000_0D0D_0000_0C0C);
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if (rd_wen !== 1'b1 || rd_addr !== 5'd12) $display("FAIL rmw_lo got wen %0b addr %0h exp 1/c", rd_wen, rd_addr); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (rd_wen !== 1'b1 || rd_addr !== 5'd13) $display("FAIL rmw_hi_state got wen %0b addr %0h exp 1/d", rd_wen, rd_addr); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if (rd_wen !== 1'b0 || busy !== 1'b0) $display("FAIL rmw_in_reset got wen %0b busy %0b exp 0/0", rd_wen, busy); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_chk++; if (rd_wen !== 1'b0 || busy !== 1'b0) $display("FAIL rmw_after got wen %0b busy %0b exp 0/0", rd_wen, busy); else n_pass++;
    n_chk++; if (rd_addr !== 5'd0) $display("FAIL rmw_no_13 got addr %0h exp 0", rd_addr); else n_pass++;
    @(negedge clock);
    offer(1'b1, 1'b0, 5'd14, 64'h1414);
    #1;
    n_chk++; if (rd_wen !== 1'b0) $display("FAIL rmw_idle got %0b exp 0", rd_wen); else n_pass++;
    @(negedge clock);
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    #1;
    n_chk++; if (rd_wen !== 1'b1 || rd_addr !== 5'd14 || rd_wdata !== 32'h1414) $display("FAIL rmw_post got wen %0b addr %0h data %0h exp 1/e/1414", rd_wen, rd_addr, rd_wdata); else n_pass++;
    @(negedge clock);
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL rmw_post_busy got %0b exp 0", busy); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    rs1_addr = '0; rs2_addr = '0; rs3_addr = '0;
    offer(1'b0, 1'b0, 5'd0, 64'h0);
    test_reset();
    test_narrow();
    test_wide();
    test_full();
    test_back_to_back();
    test_x0();
    test_hazard();
    test_reset_mid_wide();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
